// File: rtl/video_timing_gen.sv
// Source-side video timing and test-pattern generator: free-running h/v counters,
// sync/de generation and four selectable patterns, all outputs registered one clock after the counters.
module video_timing_gen #(
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        en,
    input  logic [1:0]  pat_sel,
    input  logic [23:0] solid_rgb,
    output logic        vs_out,
    output logic        hs_out,
    output logic        de_out,
    output logic [23:0] rgb_data_out,
    output logic        sof_out
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int BAR_W   = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

    localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
    localparam logic [11:0] H_ACT_N  = 12'(H_ACTIVE);
    localparam logic [11:0] V_ACT_N  = 12'(V_ACTIVE);
    localparam logic [11:0] HS_BEG   = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] VS_BEG   = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [11:0] BAR_LAST = 12'(BAR_W - 1);

    logic [11:0] h_cnt_q, h_cnt_d;
    logic [11:0] v_cnt_q, v_cnt_d;
    logic [11:0] bar_pos_q, bar_pos_d;
    logic [2:0]  bar_idx_q, bar_idx_d;
    logic [1:0]  pat_q, pat_d;
    logic [23:0] solid_q, solid_d;
    logic        vs_q, vs_d;
    logic        hs_q, hs_d;
    logic        de_q, de_d;
    logic        sof_q, sof_d;
    logic [23:0] rgb_q, rgb_d;

    logic        h_wrap;
    logic        v_wrap;
    logic        frame_start;
    logic        active;
    logic        hs_region;
    logic        vs_region;
    logic [1:0]  pat_eff;
    logic [23:0] solid_eff;
    logic [23:0] pix;

    function automatic logic [23:0] bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    return 24'hFFFFFF;
            3'd1:    return 24'hFFFF00;
            3'd2:    return 24'h00FFFF;
            3'd3:    return 24'h00FF00;
            3'd4:    return 24'hFF00FF;
            3'd5:    return 24'hFF0000;
            3'd6:    return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    assign h_wrap      = (h_cnt_q == H_LAST);
    assign v_wrap      = (v_cnt_q == V_LAST);
    assign frame_start = (h_cnt_q == 12'd0) && (v_cnt_q == 12'd0);
    assign active      = (h_cnt_q < H_ACT_N) && (v_cnt_q < V_ACT_N);
    assign hs_region   = (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END);
    assign vs_region   = (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END);

    // The first pixel of a frame already uses the freshly captured selection.
    assign pat_eff   = frame_start ? pat_sel   : pat_q;
    assign solid_eff = frame_start ? solid_rgb : solid_q;
    assign pat_d     = pat_eff;
    assign solid_d   = solid_eff;

    always_comb begin
        h_cnt_d = '0;
        v_cnt_d = '0;
        if (en) begin
            if (h_wrap) begin
                h_cnt_d = '0;
                v_cnt_d = v_wrap ? 12'd0 : v_cnt_q + 12'd1;
            end else begin
                h_cnt_d = h_cnt_q + 12'd1;
                v_cnt_d = v_cnt_q;
            end
        end
    end

    // Bar position tracks x so the bar index needs no divider; the last bar absorbs the remainder.
    always_comb begin
        bar_pos_d = '0;
        bar_idx_d = '0;
        if (en && !h_wrap) begin
            if (bar_idx_q == 3'd7) begin
                bar_pos_d = bar_pos_q;
                bar_idx_d = bar_idx_q;
            end else if (bar_pos_q == BAR_LAST) begin
                bar_pos_d = '0;
                bar_idx_d = bar_idx_q + 3'd1;
            end else begin
                bar_pos_d = bar_pos_q + 12'd1;
                bar_idx_d = bar_idx_q;
            end
        end
    end

    always_comb begin
        case (pat_eff)
            2'd0:    pix = bar_color(bar_idx_q);
            2'd1:    pix = {3{h_cnt_q[7:0]}};
            2'd2:    pix = (h_cnt_q[5] ^ v_cnt_q[5]) ? 24'hFFFFFF : 24'h000000;
            default: pix = solid_eff;
        endcase
    end

    always_comb begin
        vs_d  = ~VS_POL;
        hs_d  = ~HS_POL;
        de_d  = 1'b0;
        sof_d = 1'b0;
        rgb_d = '0;
        if (en) begin
            vs_d  = vs_region ? VS_POL : ~VS_POL;
            hs_d  = hs_region ? HS_POL : ~HS_POL;
            de_d  = active;
            sof_d = active && frame_start;
            rgb_d = active ? pix : 24'h000000;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            h_cnt_q   <= '0;
            v_cnt_q   <= '0;
            bar_pos_q <= '0;
            bar_idx_q <= '0;
            pat_q     <= '0;
            solid_q   <= '0;
            vs_q      <= ~VS_POL;
            hs_q      <= ~HS_POL;
            de_q      <= 1'b0;
            sof_q     <= 1'b0;
            rgb_q     <= '0;
        end else begin
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
            bar_pos_q <= bar_pos_d;
            bar_idx_q <= bar_idx_d;
            pat_q     <= pat_d;
            solid_q   <= solid_d;
            vs_q      <= vs_d;
            hs_q      <= hs_d;
            de_q      <= de_d;
            sof_q     <= sof_d;
            rgb_q     <= rgb_d;
        end
    end

    assign vs_out       = vs_q;
    assign hs_out       = hs_q;
    assign de_out       = de_q;
    assign sof_out      = sof_q;
    assign rgb_data_out = rgb_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen on a 24x12 raster (16x8 active).
module tb_video_timing_gen;

    localparam int FRAME = 288;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        en;
    logic [1:0]  pat_sel;
    logic [23:0] solid_rgb;
    logic        vs_out;
    logic        hs_out;
    logic        de_out;
    logic [23:0] rgb_data_out;
    logic        sof_out;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_sof = -1;

    logic [23:0] bars_tbl [16] = '{
        24'hFFFFFF, 24'hFFFFFF, 24'hFFFF00, 24'hFFFF00,
        24'h00FFFF, 24'h00FFFF, 24'h00FF00, 24'h00FF00,
        24'hFF00FF, 24'hFF00FF, 24'hFF0000, 24'hFF0000,
        24'h0000FF, 24'h0000FF, 24'h000000, 24'h000000
    };

    always #5 clk = ~clk;

    video_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(8),  .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut (
        .clk          (clk),
        .rst_b        (rst_b),
        .en           (en),
        .pat_sel      (pat_sel),
        .solid_rgb    (solid_rgb),
        .vs_out       (vs_out),
        .hs_out       (hs_out),
        .de_out       (de_out),
        .rgb_data_out (rgb_data_out),
        .sof_out      (sof_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [23:0] exp_pix(input int mode, input int x, input int y,
                                            input logic [23:0] solid);
        logic [11:0] xv;
        logic [11:0] yv;
        xv = x[11:0];
        yv = y[11:0];
        case (mode)
            0:       return bars_tbl[x];
            1:       return {3{xv[7:0]}};
            2:       return (xv[5] ^ yv[5]) ? 24'hFFFFFF : 24'h000000;
            default: return solid;
        endcase
    endfunction

    // One full frame starting at raster position (0,0); optionally changes pat_sel mid-frame.
    task automatic run_frame(input int mode, input logic [23:0] solid,
                             input int sw_line, input logic [1:0] sw_pat);
        int de_tot, vs_tot, vs_first, sof_cnt, de_line, hs_line, hs_first, x, y;
        logic act;
        de_tot = 0; vs_tot = 0; vs_first = -1; sof_cnt = 0;
        de_line = 0; hs_line = 0; hs_first = -1;
        for (int i = 0; i < FRAME; i++) begin
            step();
            x = i % 24;
            y = i / 24;
            act = (x < 16) && (y < 8);
            if (x == 0) begin
                de_line = 0; hs_line = 0; hs_first = -1;
            end
            chk("de", de_out, act);
            chk("rgb", rgb_data_out, act ? exp_pix(mode, x, y, solid) : 24'h000000);
            chk("sof", sof_out, i == 0);
            if (de_out) begin de_line++; de_tot++; end
            if (hs_out) begin
                if (hs_first < 0) hs_first = x;
                hs_line++;
            end
            if (vs_out) begin
                if (vs_first < 0) vs_first = i;
                vs_tot++;
            end
            if (sof_out) begin
                sof_cnt++;
                if (last_sof >= 0) chk("sof_spacing", cyc - last_sof, FRAME);
                last_sof = cyc;
            end
            if (x == 23) begin
                chk("de_per_line", de_line, (y < 8) ? 16 : 0);
                chk("hs_per_line", hs_line, 3);
                chk("hs_start", hs_first, 18);
            end
            if (sw_line >= 0 && i == sw_line * 24) pat_sel = sw_pat;
        end
        chk("de_per_frame", de_tot, 128);
        chk("vs_per_frame", vs_tot, 48);
        chk("vs_start", vs_first, 216);
        chk("sof_per_frame", sof_cnt, 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_b     = 1'b0;
        en        = 1'b0;
        pat_sel   = 2'd0;
        solid_rgb = 24'h000000;
        repeat (3) step();
        chk("reset_vs", vs_out, 1'b0);
        chk("reset_hs", hs_out, 1'b0);
        chk("reset_de", de_out, 1'b0);
        chk("reset_sof", sof_out, 1'b0);
        chk("reset_rgb", rgb_data_out, 24'h000000);

        rst_b = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step();
            chk("idle", {vs_out, hs_out, de_out, sof_out, rgb_data_out}, 28'h0);
        end

        en = 1'b1;
        chk("de_before_edge", de_out, 1'b0);
        for (int f = 0; f < 3; f++) run_frame(0, 24'h000000, -1, 2'd0);

        pat_sel = 2'd1;
        run_frame(1, 24'h000000, -1, 2'd0);
        pat_sel = 2'd2;
        run_frame(2, 24'h000000, -1, 2'd0);
        pat_sel   = 2'd3;
        solid_rgb = 24'h123456;
        run_frame(3, 24'h123456, -1, 2'd0);

        pat_sel = 2'd0;
        run_frame(0, 24'h000000, 4, 2'd3);
        run_frame(3, 24'h123456, -1, 2'd0);

        for (int i = 0; i < 128; i++) step();
        chk("pre_abort_de", de_out, 1'b1);
        chk("pre_abort_rgb", rgb_data_out, 24'h123456);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("abort_idle", {vs_out, hs_out, de_out, sof_out, rgb_data_out}, 28'h0);
        end
        en       = 1'b1;
        last_sof = -1;
        run_frame(3, 24'h123456, -1, 2'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
